// File: rtl/mux_2_to_1_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin mux arbiter.
//   arb_state_e      : FSM state encoding (IDLE / GNT0 / GNT1)
//   REQ0, REQ1       : requester index constants
//   max_burst_legal  : legality check for the MAX_BURST parameter (1..16)
package mux_2_to_1_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    localparam int MAX_BURST_MIN = 1;
    localparam int MAX_BURST_MAX = 16;

    function automatic bit max_burst_legal(input int mb);
        return (mb >= MAX_BURST_MIN) && (mb <= MAX_BURST_MAX);
    endfunction

endpackage

// File: rtl/mux_2_to_1.sv
// Single-bit 2:1 multiplexer, purely combinational.
//   I   [1:0] in  : data inputs, I[0] selected when sel = 0
//   sel       in  : select
//   Y         out : selected bit
module mux_2_to_1 (
    input  logic [1:0] I,
    input  logic       sel,
    output logic       Y
);

    assign Y = sel ? I[1] : I[0];

endmodule

// File: rtl/mux_2_to_1_arbiter.sv
// Round-robin arbiter sharing a 2:1 single-bit mux path between two
// requesters, with burst support (hold until last, request drop, or cap).
//   clk, rst_n        : clock, asynchronous active-low reset
//   req   [1:0] in    : request per requester; one beat per cycle while granted
//   last  [1:0] in    : final beat marker, qualified by req
//   I     [1:0] in    : data bit per requester
//   gnt   [1:0] out   : one-hot registered grant, 00 when idle
//   sel         out   : mux select (1 = requester 1), holds while idle
//   Y           out   : registered selected data bit
//   y_valid     out   : Y carries a beat this cycle
//   busy        out   : a grant is active
// Optional (macro MUX_ARB_STATS_EN):
//   stats_clr   in    : synchronous clear of both beat counters
//   beats0/1 [15:0]   : saturating delivered-beat counters per requester
//
// state | meaning
// IDLE  | no grant; arbitrate on req using prio for ties
// GNT0  | requester 0 owns the path
// GNT1  | requester 1 owns the path
module mux_2_to_1_arbiter
    import mux_2_to_1_arbiter_pkg::*;
#(
    parameter  int MAX_BURST = 4,
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  last,
    input  logic [1:0]  I,
    output logic [1:0]  gnt,
    output logic        sel,
    output logic        Y,
    output logic        y_valid,
    output logic        busy
`ifdef MUX_ARB_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [15:0] beats0,
    output logic [15:0] beats1
`endif
);

    generate
        if (!max_burst_legal(MAX_BURST)) begin : g_bad_max_burst
            $error("mux_2_to_1_arbiter: MAX_BURST must be within 1..16");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prio_q, prio_d;
    logic             sel_q, sel_d;
    logic             y_q, y_valid_q;
    logic             cur_idx;
    logic             beat;
    logic             mux_y;

    mux_2_to_1 u_mux (
        .I   (I),
        .sel (sel_q),
        .Y   (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prio_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        cur_idx = 1'b0;
        beat    = 1'b0;
        case (state_q)
            IDLE: begin
                case (req)
                    2'b01:   state_d = GNT0;
                    2'b10:   state_d = GNT1;
                    2'b11:   state_d = prio_q ? GNT1 : GNT0;
                    default: state_d = IDLE;
                endcase
            end
            GNT0, GNT1: begin
                cur_idx = (state_q == GNT1);
                beat    = req[cur_idx];
                // A dropped request ends the burst even without a beat.
                if (!req[cur_idx] || last[cur_idx] || (cnt_q == CNT_CAP)) begin
                    prio_d = ~cur_idx;
                    cnt_d  = '0;
                    if (req[~cur_idx]) begin
                        state_d = cur_idx ? GNT0 : GNT1;
                    end else if (req[cur_idx] && !last[cur_idx]) begin
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // sel follows the granted requester and keeps its last value in IDLE,
    // so the mux input does not toggle while the path is unused.
    always_comb begin
        sel_d = sel_q;
        case (state_d)
            GNT0:    sel_d = 1'b0;
            GNT1:    sel_d = 1'b1;
            default: sel_d = sel_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= beat;
            if (beat) begin
                y_q <= mux_y;
            end
        end
    end

    assign gnt     = {state_q == GNT1, state_q == GNT0};
    assign busy    = (state_q != IDLE);
    assign sel     = sel_q;
    assign Y       = y_q;
    assign y_valid = y_valid_q;

`ifdef MUX_ARB_STATS_EN
    logic [15:0] beats0_q, beats1_q;
    logic        beat0, beat1;

    assign beat0 = beat && (cur_idx == 1'(REQ0));
    assign beat1 = beat && (cur_idx == 1'(REQ1));

    // Clear takes precedence over a beat in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats0_q <= '0;
            beats1_q <= '0;
        end else if (stats_clr) begin
            beats0_q <= '0;
            beats1_q <= '0;
        end else begin
            if (beat0 && (beats0_q != 16'hFFFF)) begin
                beats0_q <= beats0_q + 16'd1;
            end
            if (beat1 && (beats1_q != 16'hFFFF)) begin
                beats1_q <= beats1_q + 16'd1;
            end
        end
    end

    assign beats0 = beats0_q;
    assign beats1 = beats1_q;
`endif

endmodule

// File: tb/tb_mux_2_to_1_arbiter.sv
module tb_mux_2_to_1_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  last;
    logic [1:0]  din;
    logic [1:0]  gnt;
    logic        sel;
    logic        Y;
    logic        y_valid;
    logic        busy;
    logic        stats_clr;
`ifdef MUX_ARB_STATS_EN
    logic [15:0] beats0;
    logic [15:0] beats1;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the path, how many beats this burst has
    // delivered, and who wins the next tie.
    int   m_owner;
    int   m_burst;
    int   m_prio;
    logic m_sel;
    logic m_y;
    logic m_v;
    int   m_b0;
    int   m_b1;

    mux_2_to_1_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .last    (last),
        .I       (din),
        .gnt     (gnt),
        .sel     (sel),
        .Y       (Y),
        .y_valid (y_valid),
        .busy    (busy)
`ifdef MUX_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .beats0    (beats0),
        .beats1    (beats1)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_burst = 0;
        m_prio  = 0;
        m_sel   = 1'b0;
        m_y     = 1'b0;
        m_v     = 1'b0;
        m_b0    = 0;
        m_b1    = 0;
    endtask

    task automatic model_step();
        int nxt;
        int n;
        int o;
        if (!rst_n) begin
            model_reset();
            return;
        end
        nxt = m_owner;
        m_v = 1'b0;
        if (m_owner < 0) begin
            if (req == 2'b11)      nxt = m_prio;
            else if (req == 2'b01) nxt = 0;
            else if (req == 2'b10) nxt = 1;
        end else begin
            n = m_owner;
            o = 1 - n;
            if (req[n]) begin
                m_y = din[n];
                m_v = 1'b1;
                m_burst++;
                if (n == 0 && m_b0 < 65535) m_b0++;
                if (n == 1 && m_b1 < 65535) m_b1++;
            end
            if (!req[n] || last[n] || m_burst == MAX_BURST) begin
                m_prio  = o;
                m_burst = 0;
                if (req[o])                  nxt = o;
                else if (req[n] && !last[n]) nxt = n;
                else                         nxt = -1;
            end
        end
        if (stats_clr) begin
            m_b0 = 0;
            m_b1 = 0;
        end
        m_owner = nxt;
        if (nxt >= 0) m_sel = (nxt == 1);
    endtask

    function automatic logic [5:0] exp_vec();
        logic [1:0] g;
        g = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
        return {g, m_sel, m_y, m_v, (m_owner >= 0)};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 2'b00;
        last      = 2'b00;
        din       = 2'b00;
        stats_clr = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 2'b11;
        last      = 2'b00;
        din       = 2'b11;
        stats_clr = 1'b0;
        tick();
        tick();
        checks++;
        if ({gnt, sel, Y, y_valid, busy} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", {gnt, sel, Y, y_valid, busy}, 6'b000000);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: got %b want 01", gnt);
        end
        checks++;
        if ({gnt, sel, Y, y_valid, busy} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %b want %b", {gnt, sel, Y, y_valid, busy}, exp_vec());
        end
    endtask

    task automatic test_single();
        logic [2:0] pat;
        pat = 3'b101;
        do_reset();
        req = 2'b01;
        tick();
        for (int i = 0; i < 3; i++) begin
            din  = {1'b0, pat[i]};
            last = {1'b0, (i == 2)};
            tick();
            checks++;
            if (Y !== pat[i] || y_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_beat%0d: got Y=%b v=%b want Y=%b v=1", i, Y, y_valid, pat[i]);
            end
            checks++;
            if ({gnt, sel, Y, y_valid, busy} !== exp_vec()) begin
                errors++;
                $display("FAIL single_model%0d: got %b want %b", i, {gnt, sel, Y, y_valid, busy}, exp_vec());
            end
        end
        req  = 2'b00;
        last = 2'b00;
        tick();
        checks++;
        if (gnt !== 2'b00 || y_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got gnt=%b v=%b busy=%b want 00 0 0", gnt, y_valid, busy);
        end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        do_reset();
        req  = 2'b11;
        din  = 2'b10;
        tick();
        for (int i = 0; i < 12; i++) begin
            want = (((i / MAX_BURST) % 2) == 0) ? 2'b01 : 2'b10;
            checks++;
            if (gnt !== want) begin
                errors++;
                $display("FAIL contention_gnt%0d: got %b want %b", i, gnt, want);
            end
            checks++;
            if ({gnt, sel, Y, y_valid, busy} !== exp_vec()) begin
                errors++;
                $display("FAIL contention_model%0d: got %b want %b", i, {gnt, sel, Y, y_valid, busy}, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_last_handover();
        do_reset();
        req  = 2'b10;
        last = 2'b00;
        tick();
        tick();
        req  = 2'b11;
        last = 2'b10;
        tick();
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL handover_gnt: got %b want 01", gnt);
        end
        // Finish requester 0 alone; prio must now favour requester 1.
        req  = 2'b01;
        last = 2'b01;
        tick();
        checks++;
        if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL handover_idle: got %b want 00", gnt);
        end
        req  = 2'b11;
        last = 2'b00;
        tick();
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL handover_prio: got %b want 10", gnt);
        end
        checks++;
        if ({gnt, sel, Y, y_valid, busy} !== exp_vec()) begin
            errors++;
            $display("FAIL handover_model: got %b want %b", {gnt, sel, Y, y_valid, busy}, exp_vec());
        end
    endtask

    task automatic test_midburst_reset();
        do_reset();
        din = 2'b11;
        req = 2'b01;
        tick();
        tick();
        tick();
        checks++;
        if (y_valid !== 1'b1 || Y !== 1'b1 || gnt !== 2'b01) begin
            errors++;
            $display("FAIL midburst_pre: got gnt=%b Y=%b v=%b want 01 1 1", gnt, Y, y_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, sel, Y, y_valid, busy} !== 6'b000000) begin
            errors++;
            $display("FAIL midburst_async_clear: got %b want %b", {gnt, sel, Y, y_valid, busy}, 6'b000000);
        end
        model_reset();
        req = 2'b10;
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (gnt !== 2'b10 || sel !== 1'b1) begin
            errors++;
            $display("FAIL midburst_regrant: got gnt=%b sel=%b want 10 1", gnt, sel);
        end
    endtask

`ifdef MUX_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req = 2'b01;
        tick();
        for (int i = 0; i < 5; i++) begin
            last = (i == 4) ? 2'b01 : 2'b00;
            tick();
        end
        req  = 2'b10;
        last = 2'b00;
        tick();
        for (int i = 0; i < 3; i++) begin
            last = (i == 2) ? 2'b10 : 2'b00;
            tick();
        end
        req  = 2'b00;
        last = 2'b00;
        tick();
        checks++;
        if (beats0 !== 16'd5 || beats1 !== 16'd3) begin
            errors++;
            $display("FAIL stats_counts: got %0d/%0d want 5/3", beats0, beats1);
        end
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        checks++;
        if (beats0 !== 16'd0 || beats1 !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear: got %0d/%0d want 0/0", beats0, beats1);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req       = 2'($urandom);
            last      = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
            din       = 2'($urandom);
            stats_clr = ($urandom_range(31) == 0);
            tick();
            checks++;
            if ({gnt, sel, Y, y_valid, busy} !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b want %b", i, {gnt, sel, Y, y_valid, busy}, exp_vec());
            end
`ifdef MUX_ARB_STATS_EN
            checks++;
            if (beats0 !== 16'(m_b0) || beats1 !== 16'(m_b1)) begin
                errors++;
                $display("FAIL random_stats%0d: got %0d/%0d want %0d/%0d", i, beats0, beats1, m_b0, m_b1);
            end
`endif
        end
        stats_clr = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_last_handover();
        test_midburst_reset();
`ifdef MUX_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
